// File: rtl/scan_dump_pkg.sv
// Shared state encoding, ASCII constants and counter sizing for the scan-dump sequencer.
package scan_dump_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR,
      S_SAMPLE,
      S_EMIT,
      S_WRAP,
      S_SHIFT,
      S_TERM,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [7:0] CH_H    = 8'h48;
   localparam logic [7:0] CH_L    = 8'h4C;
   localparam logic [7:0] CH_NL   = 8'h0A;
   localparam logic [7:0] CH_HASH = 8'h23;
   localparam logic [7:0] CH_ZERO = 8'h30;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/scan_clk_pulser.sv
// Generates `count` CSoC clock pulses (1 cycle high, 1 cycle low) per go strobe;
// done strobes during the final low phase so the caller can move on immediately.
module scan_clk_pulser #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [CNT_W-1:0] count,
   output logic             pulse,
   output logic             done
);

   logic             active;
   logic [CNT_W-1:0] remain;

   always_ff @(posedge clk) begin
      done <= 1'b0;
      if (rst) begin
         active <= 1'b0;
         pulse  <= 1'b0;
         remain <= '0;
      end else if (!active) begin
         if (go && count != '0) begin
            active <= 1'b1;
            pulse  <= 1'b1;
            remain <= count - 1'b1;
         end
      end else if (pulse) begin
         pulse <= 1'b0;
         if (remain == '0) begin
            active <= 1'b0;
            done   <= 1'b1;
         end
      end else begin
         pulse  <= 1'b1;
         remain <= remain - 1'b1;
      end
   end

endmodule

// File: rtl/scan_dump_ctrl.sv
// Captures NUM_CHAINS scan chains from the CSoC and streams them as 'H'/'L' text over
// the UART handshake, alternating NUM_DUMPS dumps with functional run bursts.
module scan_dump_ctrl
   import scan_dump_pkg::*;
#(
   parameter int NUM_CHAINS = 1,
   parameter int CHAIN_LEN  = 20,
   parameter int MAX_COL    = 8,
   parameter int RUN_TICKS  = 6,
   parameter int NUM_DUMPS  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  tx_start_o,
   output logic [7:0]            tx_data_o,
   input  logic                  tx_ready_i,
   output logic                  csoc_clk,
   output logic                  csoc_rstn,
   output logic                  csoc_test_se,
   output logic                  csoc_test_tm,
   input  logic [NUM_CHAINS-1:0] scan_out_i
);

   localparam int CHW  = cnt_w(NUM_CHAINS - 1);
   localparam int SW   = cnt_w(CHAIN_LEN - 1);
   localparam int COLW = cnt_w(MAX_COL);
   localparam int DW   = cnt_w(NUM_DUMPS - 1);
   localparam int PW   = cnt_w(RUN_TICKS);

   localparam logic [CHW-1:0]  CH_LAST   = CHW'(NUM_CHAINS - 1);
   localparam logic [SW-1:0]   STEP_LAST = SW'(CHAIN_LEN - 1);
   localparam logic [COLW-1:0] COL_MAX   = COLW'(MAX_COL);
   localparam logic [DW-1:0]   DUMP_LAST = DW'(NUM_DUMPS - 1);

   state_t                  state;
   logic [DW-1:0]           dump_idx;
   logic [SW-1:0]           step;
   logic [COLW-1:0]         col;
   logic [CHW-1:0]          ch;
   logic [1:0]              hdr_idx;
   logic                    chain_end;
   logic [NUM_CHAINS-1:0]   snap;
   logic                    pls_go;
   logic [PW-1:0]           pls_cnt;
   logic                    pls_done;

   logic                    tx_acc;
   logic                    sends_char;
   logic                    ch_last;
   logic                    step_last;
   logic                    dump_last;
   logic [7:0]              next_char;

   assign tx_acc    = tx_start_o && tx_ready_i;
   assign ch_last   = (ch == CH_LAST);
   assign step_last = (step == STEP_LAST);
   assign dump_last = (dump_idx == DUMP_LAST);
   assign sends_char = (state == S_HDR) || (state == S_EMIT) || (state == S_WRAP) ||
                       ((state == S_TERM) && (col != '0));

   // snap is shifted after each accepted chain, so bit 0 is always the current chain
   always_comb begin
      next_char = CH_NL;
      case (state)
         S_HDR: begin
            if (hdr_idx == 2'd0)      next_char = CH_HASH;
            else if (hdr_idx == 2'd1) next_char = CH_ZERO + 8'(dump_idx);
         end
         S_EMIT:  next_char = snap[0] ? CH_H : CH_L;
         default: next_char = CH_NL;
      endcase
   end

   scan_clk_pulser #(
      .CNT_W (PW)
   ) u_pulser (
      .clk   (clk),
      .rst   (rst),
      .go    (pls_go),
      .count (pls_cnt),
      .pulse (csoc_clk),
      .done  (pls_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         tx_start_o   <= 1'b0;
         tx_data_o    <= 8'h00;
         csoc_rstn    <= 1'b0;
         csoc_test_se <= 1'b1;
         csoc_test_tm <= 1'b1;
         pls_go       <= 1'b0;
         pls_cnt      <= '0;
         dump_idx     <= '0;
         step         <= '0;
         col          <= '0;
         ch           <= '0;
         hdr_idx      <= '0;
         chain_end    <= 1'b0;
      end else begin
         pls_go <= 1'b0;
         if (sends_char && !tx_start_o) begin
            tx_start_o <= 1'b1;
            tx_data_o  <= next_char;
         end
         case (state)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state     <= S_HDR;
                  busy_o    <= 1'b1;
                  done_o    <= 1'b0;
                  csoc_rstn <= 1'b1;
                  dump_idx  <= '0;
                  step      <= '0;
                  col       <= '0;
                  hdr_idx   <= '0;
               end
            end
            S_HDR: begin
               if (tx_acc) begin
                  tx_start_o <= 1'b0;
                  if (hdr_idx == 2'd2) begin
                     hdr_idx <= '0;
                     state   <= S_SAMPLE;
                  end else begin
                     hdr_idx <= hdr_idx + 2'd1;
                  end
               end
            end
            S_SAMPLE: begin
               snap  <= scan_out_i;
               ch    <= '0;
               state <= S_EMIT;
            end
            S_EMIT: begin
               if (tx_acc) begin
                  tx_start_o <= 1'b0;
                  col        <= col + 1'b1;
                  snap       <= snap >> 1;
                  chain_end  <= ch_last;
                  if (!ch_last) ch <= ch + 1'b1;
                  if (col + 1'b1 == COL_MAX) begin
                     state <= S_WRAP;
                  end else if (ch_last) begin
                     if (step_last) begin
                        state <= S_TERM;
                     end else begin
                        state   <= S_SHIFT;
                        pls_go  <= 1'b1;
                        pls_cnt <= PW'(1);
                     end
                  end
               end
            end
            S_WRAP: begin
               if (tx_acc) begin
                  tx_start_o <= 1'b0;
                  col        <= '0;
                  if (!chain_end) begin
                     state <= S_EMIT;
                  end else if (step_last) begin
                     state <= S_TERM;
                  end else begin
                     state   <= S_SHIFT;
                     pls_go  <= 1'b1;
                     pls_cnt <= PW'(1);
                  end
               end
            end
            S_SHIFT: begin
               if (pls_done) begin
                  step  <= step + 1'b1;
                  state <= S_SAMPLE;
               end
            end
            // A wrap that just cleared col leaves nothing to terminate
            S_TERM: begin
               if (col == '0 || tx_acc) begin
                  tx_start_o <= 1'b0;
                  col        <= '0;
                  if (dump_last) begin
                     state  <= S_DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     state        <= S_RUN;
                     csoc_test_se <= 1'b0;
                     csoc_test_tm <= 1'b0;
                     pls_go       <= 1'b1;
                     pls_cnt      <= PW'(RUN_TICKS);
                  end
               end
            end
            S_RUN: begin
               if (pls_done) begin
                  csoc_test_se <= 1'b1;
                  csoc_test_tm <= 1'b1;
                  dump_idx     <= dump_idx + 1'b1;
                  step         <= '0;
                  hdr_idx      <= '0;
                  state        <= S_HDR;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
